// File: rtl/ov7670_pkg.sv
// ---------------------------------------------------------------------------
// ov7670_pkg
// Shared definitions for the OV7670 classifier back end:
//   - colour and shape code constants produced by the classifier
//   - result_code_t : packed {shape, colour} pair (4 bits)
//   - state_t       : result filter FSM encoding
//   - make_code()   : builds a result_code_t from separate shape/colour codes
// ---------------------------------------------------------------------------
package ov7670_pkg;

  localparam logic [1:0] COLOR_NONE     = 2'b00;
  localparam logic [1:0] COLOR_RED      = 2'b01;
  localparam logic [1:0] COLOR_GREEN    = 2'b10;
  localparam logic [1:0] COLOR_BLUE     = 2'b11;

  localparam logic [1:0] SHAPE_NONE     = 2'b00;
  localparam logic [1:0] SHAPE_SQUARE   = 2'b01;
  localparam logic [1:0] SHAPE_TRIANGLE = 2'b10;
  localparam logic [1:0] SHAPE_OTHER    = 2'b11;

  typedef struct packed {
    logic [1:0] shape;
    logic [1:0] colour;
  } result_code_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_VOTE    = 2'd2,
    ST_PUBLISH = 2'd3
  } state_t;

  function automatic result_code_t make_code(input logic [1:0] shape,
                                             input logic [1:0] colour);
    result_code_t code;
    code.shape  = shape;
    code.colour = colour;
    return code;
  endfunction

endpackage

// File: rtl/ov7670_vote_counter.sv
// ---------------------------------------------------------------------------
// ov7670_vote_counter
// History of the last WINDOW frame results plus a sequential match counter.
// i_shift pushes i_code into entry 0 (oldest entry falls out) and bumps the
// fill level, saturating at WINDOW. i_start begins a WINDOW-cycle scan that
// counts the valid entries equal to the newest entry (the newest entry
// counts itself). o_done is high in the last scan cycle; o_match is final
// on the cycle after o_done.
//
// Ports:
//   Pclock    in   pixel clock
//   Reset     in   synchronous, active-high
//   i_flush   in   clear history and fill (idle timeout)
//   i_shift   in   push i_code as the newest entry
//   i_code    in   {shape, colour} result to push
//   i_start   in   restart the match scan
//   o_done    out  last scan cycle
//   o_match   out  number of history entries equal to the newest one
//   o_newest  out  newest history entry
// ---------------------------------------------------------------------------
module ov7670_vote_counter
  import ov7670_pkg::*;
#(
  parameter int WINDOW = 4
) (
  input  logic                        Pclock,
  input  logic                        Reset,
  input  logic                        i_flush,
  input  logic                        i_shift,
  input  result_code_t                i_code,
  input  logic                        i_start,
  output logic                        o_done,
  output logic [$clog2(WINDOW+1)-1:0] o_match,
  output result_code_t                o_newest
);

  localparam int MW = $clog2(WINDOW + 1);
  localparam int IW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  result_code_t    r_hist [WINDOW];
  logic [MW-1:0]   r_fill;
  logic [MW-1:0]   r_match;
  logic [IW-1:0]   r_idx;
  logic            r_busy;
  logic            w_hit;

  // Entries at or beyond the fill level are stale and never vote.
  assign w_hit    = (MW'(r_idx) < r_fill) && (r_hist[r_idx] == r_hist[0]);
  assign o_done   = r_busy && (r_idx == IW'(WINDOW - 1));
  assign o_match  = r_match;
  assign o_newest = r_hist[0];

  // NOTE: the history is a handful of flops, so it is cleared on reset along
  // with fill; larger storage would normally rely on fill alone and skip it.
  always_ff @(posedge Pclock) begin
    if (Reset || i_flush) begin
      for (int i = 0; i < WINDOW; i++) r_hist[i] <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      r_hist[0] <= i_code;
      for (int i = 1; i < WINDOW; i++) r_hist[i] <= r_hist[i-1];
      if (r_fill != MW'(WINDOW)) r_fill <= r_fill + MW'(1);
    end
  end

  always_ff @(posedge Pclock) begin
    if (Reset) begin
      r_busy  <= 1'b0;
      r_idx   <= '0;
      r_match <= '0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_idx   <= '0;
      r_match <= '0;
    end else if (r_busy) begin
      if (w_hit) r_match <= r_match + MW'(1);
      if (r_idx == IW'(WINDOW - 1)) r_busy <= 1'b0;
      else                          r_idx  <= r_idx + IW'(1);
    end
  end

endmodule

// File: rtl/ov7670_result_filter.sv
// ---------------------------------------------------------------------------
// ov7670_result_filter
// Debounces the per-frame classifier result: a {Forma, Promedio} pair is
// published only when at least MIN_AGREE of the last WINDOW frames agree and
// the colour is not COLOR_NONE. The published pair is offered to the SoC
// register bank through a Result_valid / Result_ack handshake.
//
// Build option: OV_FILTER_TIMEOUT_EN
//   defined   - after TIMEOUT_CYCLES Pclock cycles without a frame the history
//               is flushed and Color_out/Shape_out/Result_valid/Stable clear.
//   undefined - no idle counter; outputs hold while the camera is stopped.
//
// Ports:
//   Pclock        in   pixel clock (classifier domain)
//   Reset         in   synchronous, active-high
//   Vsync         in   camera frame sync
//   Promedio      in   classifier colour code
//   Forma         in   classifier shape code
//   Result_ack    in   reader acknowledge (pulse or level)
//   Color_out     out  published colour code
//   Shape_out     out  published shape code
//   Result_valid  out  published result not yet acknowledged
//   Overrun       out  sticky: pending result replaced by a different one
//   Stable        out  newest frame equals the published result
// ---------------------------------------------------------------------------
module ov7670_result_filter
  import ov7670_pkg::*;
#(
  parameter int WINDOW    = 4,
  parameter int MIN_AGREE = 3
`ifdef OV_FILTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 2000000
`endif
) (
  input  logic       Pclock,
  input  logic       Reset,
  input  logic       Vsync,
  input  logic [1:0] Promedio,
  input  logic [1:0] Forma,
  input  logic       Result_ack,
  output logic [1:0] Color_out,
  output logic [1:0] Shape_out,
  output logic       Result_valid,
  output logic       Overrun,
  output logic       Stable
);

  localparam int MW = $clog2(WINDOW + 1);

  state_t        r_state;
  logic          r_vs_d;
  logic          r_rise_d;
  logic          r_pending;
  result_code_t  r_code;

  logic          w_rise;
  logic          w_accept;
  logic          w_capture;
  logic          w_done;
  logic [MW-1:0] w_match;
  result_code_t  w_newest;
  result_code_t  w_pub_code;
  logic          w_differs;
  logic          w_publish;
  logic          w_flush;

  // The classifier updates Promedio/Forma on the Vsync rising edge, so the
  // strobe is delayed one cycle before the codes are sampled.
  assign w_rise = Vsync & ~r_vs_d;

  // A strobe is taken unless a frame is already queued. In CAPTURE the queued
  // frame is being consumed on this very edge, so a new one may take its slot.
  assign w_accept  = r_rise_d & (~r_pending | (r_state == ST_CAPTURE));
  assign w_capture = (r_state == ST_CAPTURE);

  assign w_pub_code = make_code(Shape_out, Color_out);
  assign w_differs  = (w_newest != w_pub_code);
  assign w_publish  = (w_match >= MW'(MIN_AGREE))
                   && (w_newest.colour != COLOR_NONE)
                   && (!Result_valid || w_differs);

  ov7670_vote_counter #(
    .WINDOW (WINDOW)
  ) u_vote (
    .Pclock   (Pclock),
    .Reset    (Reset),
    .i_flush  (w_flush),
    .i_shift  (w_capture),
    .i_code   (r_code),
    .i_start  (w_capture),
    .o_done   (w_done),
    .o_match  (w_match),
    .o_newest (w_newest)
  );

`ifdef OV_FILTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_idle_cnt;

  // Fires on the edge where the count reaches TIMEOUT_CYCLES; the counter
  // then parks there so the flush happens once per silence.
  assign w_flush = !r_rise_d && (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Pclock) begin
    if (Reset || r_rise_d) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt != TW'(TIMEOUT_CYCLES)) begin
      r_idle_cnt <= r_idle_cnt + TW'(1);
    end
  end
`else
  assign w_flush = 1'b0;
`endif

  always_ff @(posedge Pclock) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_vs_d       <= 1'b0;
      r_rise_d     <= 1'b0;
      r_pending    <= 1'b0;
      r_code       <= '0;
      Color_out    <= COLOR_NONE;
      Shape_out    <= SHAPE_NONE;
      Result_valid <= 1'b0;
      Overrun      <= 1'b0;
      Stable       <= 1'b0;
    end else begin
      r_vs_d   <= Vsync;
      r_rise_d <= w_rise;

      if (w_accept) r_code <= make_code(Forma, Promedio);

      // NOTE: non-blocking assignments resolve last-write-wins, so a publish
      // further down overrides this acknowledge clear on the same edge.
      if (Result_ack) Result_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (r_rise_d || r_pending) r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          r_pending <= w_accept;
          r_state   <= ST_VOTE;
        end
        ST_VOTE: begin
          if (w_accept) r_pending <= 1'b1;
          if (w_done)   r_state   <= ST_PUBLISH;
        end
        ST_PUBLISH: begin
          if (w_accept) r_pending <= 1'b1;
          if (w_publish) begin
            Color_out    <= w_newest.colour;
            Shape_out    <= w_newest.shape;
            Result_valid <= 1'b1;
            if (Result_valid) Overrun <= 1'b1;
          end
          // A zero colour on the outputs means nothing has been published,
          // so an all-zero newest code is not "stable" against it.
          Stable  <= w_publish || (!w_differs && (Color_out != COLOR_NONE));
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_flush) begin
        Color_out    <= COLOR_NONE;
        Shape_out    <= SHAPE_NONE;
        Result_valid <= 1'b0;
        Stable       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_result_filter.sv
// ---------------------------------------------------------------------------
// tb_ov7670_result_filter
// Self-checking bench for ov7670_result_filter (WINDOW=4, MIN_AGREE=3):
// a table of frame sequences with expected outputs, hand-written sequences
// for latency, handshake, queued frames and reset mid-vote, the idle
// timeout when OV_FILTER_TIMEOUT_EN is defined, and random frames compared
// against a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_ov7670_result_filter;
  import ov7670_pkg::*;

  localparam int WINDOW    = 4;
  localparam int MIN_AGREE = 3;

  logic       Pclock = 1'b0;
  logic       Reset;
  logic       Vsync;
  logic [1:0] Promedio;
  logic [1:0] Forma;
  logic       Result_ack;
  logic [1:0] Color_out;
  logic [1:0] Shape_out;
  logic       Result_valid;
  logic       Overrun;
  logic       Stable;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Pclock = ~Pclock;

  ov7670_result_filter #(
    .WINDOW         (WINDOW),
    .MIN_AGREE      (MIN_AGREE)
`ifdef OV_FILTER_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (100)
`endif
  ) dut (
    .Pclock       (Pclock),
    .Reset        (Reset),
    .Vsync        (Vsync),
    .Promedio     (Promedio),
    .Forma        (Forma),
    .Result_ack   (Result_ack),
    .Color_out    (Color_out),
    .Shape_out    (Shape_out),
    .Result_valid (Result_valid),
    .Overrun      (Overrun),
    .Stable       (Stable)
  );

  typedef struct {
    bit         rst;
    bit         ack;
    logic [1:0] colour;
    logic [1:0] shape;
    logic [1:0] e_c;
    logic [1:0] e_s;
    logic       e_v;
    logic       e_o;
    logic       e_st;
  } vec_t;

  vec_t vecs [16];

  // Reference model state (frame level).
  int         m_hist [$];
  logic [3:0] m_pub;
  logic       m_valid;
  logic       m_ov;
  logic       m_stable;
  logic [3:0] pool [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Pclock);
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] c, input logic [1:0] s,
                               input logic v, input logic o, input logic st);
    check({tag, ".colour"}, 32'(Color_out),    32'(c));
    check({tag, ".shape"},  32'(Shape_out),    32'(s));
    check({tag, ".valid"},  32'(Result_valid), 32'(v));
    check({tag, ".overrun"},32'(Overrun),      32'(o));
    check({tag, ".stable"}, 32'(Stable),       32'(st));
  endtask

  task automatic do_reset;
    Reset      = 1'b1;
    Vsync      = 1'b0;
    Result_ack = 1'b0;
    Promedio   = 2'b00;
    Forma      = 2'b00;
    tick(2);
    Reset = 1'b0;
    tick(1);
  endtask

  // One frame: codes change with the Vsync rise, processing completes well
  // inside the 12 cycles before the task returns.
  task automatic frame(input logic [1:0] colour, input logic [1:0] shape);
    Promedio = colour;
    Forma    = shape;
    Vsync    = 1'b1;
    tick(3);
    Vsync = 1'b0;
    tick(9);
  endtask

  task automatic pulse_ack;
    Result_ack = 1'b1;
    tick(1);
    Result_ack = 1'b0;
  endtask

  // Frame-level model: keep the last WINDOW codes, count agreement with the
  // newest, publish when enough agree and colour is non-zero.
  task automatic model_frame(input logic [3:0] code);
    int  agree;
    bit  pub;
    m_hist.push_front(int'(code));
    if (m_hist.size() > WINDOW) void'(m_hist.pop_back());
    agree = 0;
    foreach (m_hist[i]) if (m_hist[i] == int'(code)) agree++;
    pub = (agree >= MIN_AGREE) && (code[1:0] != 2'b00) && (!m_valid || code != m_pub);
    if (pub) begin
      if (m_valid) m_ov = 1'b1;
      m_pub   = code;
      m_valid = 1'b1;
    end
    m_stable = (code == m_pub) && (m_pub[1:0] != 2'b00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] code;

    //             rst ack col    shp    e_c    e_s    v  o  st
    vecs[0]  = '{0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0};
    vecs[1]  = '{0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0};
    vecs[2]  = '{0, 0, 2'b01, 2'b01, 2'b01, 2'b01, 1, 0, 1};
    vecs[3]  = '{0, 0, 2'b11, 2'b10, 2'b01, 2'b01, 1, 0, 0};
    vecs[4]  = '{0, 0, 2'b11, 2'b10, 2'b01, 2'b01, 1, 0, 0};
    vecs[5]  = '{0, 0, 2'b11, 2'b10, 2'b11, 2'b10, 1, 1, 1};
    vecs[6]  = '{0, 1, 2'b11, 2'b10, 2'b11, 2'b10, 1, 1, 1};
    vecs[7]  = '{1, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0};
    vecs[8]  = '{0, 0, 2'b10, 2'b11, 2'b00, 2'b00, 0, 0, 0};
    vecs[9]  = '{0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0};
    vecs[10] = '{0, 0, 2'b10, 2'b11, 2'b00, 2'b00, 0, 0, 0};
    vecs[11] = '{0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0};
    vecs[12] = '{1, 0, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0};
    vecs[13] = '{0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0};
    vecs[14] = '{0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0};
    vecs[15] = '{0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0};

    pool[0] = {SHAPE_SQUARE,   COLOR_RED};
    pool[1] = {SHAPE_TRIANGLE, COLOR_BLUE};
    pool[2] = {SHAPE_SQUARE,   COLOR_NONE};
    pool[3] = {SHAPE_OTHER,    COLOR_GREEN};

    // Reset state
    do_reset();
    check_outputs("reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Table-driven frame sequences
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].rst) do_reset();
      if (vecs[i].ack) pulse_ack();
      frame(vecs[i].colour, vecs[i].shape);
      check_outputs($sformatf("vec%0d", i), vecs[i].e_c, vecs[i].e_s,
                    vecs[i].e_v, vecs[i].e_o, vecs[i].e_st);
    end

    // Publish latency: Result_valid rises 7 edges after the Vsync rise edge
    do_reset();
    frame(COLOR_RED, SHAPE_SQUARE);
    frame(COLOR_RED, SHAPE_SQUARE);
    Promedio = COLOR_RED;
    Forma    = SHAPE_SQUARE;
    Vsync    = 1'b1;
    tick(7);
    check("lat.early_valid", 32'(Result_valid), 32'd0);
    tick(1);
    check_outputs("lat.on_time", 2'b01, 2'b01, 1'b1, 1'b0, 1'b1);
    tick(10);                 // Vsync held high: still a single strobe
    Vsync = 1'b0;
    tick(4);
    check("lat.held_vsync_valid", 32'(Result_valid), 32'd1);

    // Acknowledge clears valid on the sampling edge, outputs held
    pulse_ack();
    check_outputs("ack", 2'b01, 2'b01, 1'b0, 1'b0, 1'b1);
    tick(3);
    check("ack.stays_low", 32'(Result_valid), 32'd0);

    // Frame queued during VOTE; a third rise while queued is dropped
    do_reset();
    Promedio = COLOR_RED;
    Forma    = SHAPE_SQUARE;
    Vsync    = 1'b1;
    tick(2);
    Vsync = 1'b0;
    tick(1);
    Vsync = 1'b1;             // second rise, lands in VOTE, same code
    tick(2);
    Vsync    = 1'b0;
    Promedio = COLOR_BLUE;
    Forma    = SHAPE_TRIANGLE;
    tick(1);
    Vsync = 1'b1;             // third rise, lands in PUBLISH with a frame queued
    tick(3);
    Vsync = 1'b0;
    tick(30);
    check("pend.no_publish", 32'(Result_valid), 32'd0);
    frame(COLOR_RED, SHAPE_SQUARE);
    check_outputs("pend.third_frame", 2'b01, 2'b01, 1'b1, 1'b0, 1'b1);

    // Reset in the second VOTE cycle
    do_reset();
    frame(COLOR_GREEN, SHAPE_OTHER);
    frame(COLOR_GREEN, SHAPE_OTHER);
    frame(COLOR_GREEN, SHAPE_OTHER);
    check("rstvote.published", 32'(Result_valid), 32'd1);
    Vsync = 1'b1;
    tick(3);
    Vsync = 1'b0;
    tick(1);
    Reset = 1'b1;
    tick(1);
    check_outputs("rstvote", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
    tick(2);
    frame(COLOR_GREEN, SHAPE_OTHER);
    frame(COLOR_GREEN, SHAPE_OTHER);
    check("rstvote.history_cleared", 32'(Result_valid), 32'd0);

`ifdef OV_FILTER_TIMEOUT_EN
    // Idle timeout (TIMEOUT_CYCLES=100)
    do_reset();
    frame(COLOR_BLUE, SHAPE_OTHER);
    frame(COLOR_BLUE, SHAPE_OTHER);
    frame(COLOR_BLUE, SHAPE_OTHER);
    tick(60);
    check_outputs("tmo.before", 2'b11, 2'b11, 1'b1, 1'b0, 1'b1);
    tick(60);
    check_outputs("tmo.after", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    frame(COLOR_BLUE, SHAPE_OTHER);
    frame(COLOR_BLUE, SHAPE_OTHER);
    check("tmo.history_flushed", 32'(Result_valid), 32'd0);
`endif

    // Random frames against the frame-level model
    do_reset();
    m_hist.delete();
    m_pub    = 4'h0;
    m_valid  = 1'b0;
    m_ov     = 1'b0;
    m_stable = 1'b0;
    for (int n = 0; n < 80; n++) begin
      code = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 2) == 0) begin
        pulse_ack();
        m_valid = 1'b0;
      end
      frame(code[1:0], code[3:2]);
      model_frame(code);
      check_outputs($sformatf("rand%0d", n), m_pub[1:0], m_pub[3:2],
                    m_valid, m_ov, m_stable);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
